// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU (absolute priority, never stalled) and a DMA master
// that issues bursts one beat at a time in CPU-idle cycles.
module mem_bus_arbiter #(
   parameter int ADDR_STEP = 2,
   parameter int LEN_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_memread,
   input  logic [1:0]       cpu_memwrite,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [31:0]      dma_addr,
   input  logic [LEN_W-1:0] dma_len,
   input  logic [31:0]      dma_wdata,
   output logic             dma_gnt,
   output logic             dma_beat,
   output logic [31:0]      dma_rdata,
   output logic             dma_rvalid,
   output logic             dma_done,
   output logic             mem_read,
   output logic [1:0]       mem_write,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [31:0]      ADDR_INC = 32'(ADDR_STEP);

   state_e           state_q, state_d;
   logic             we_q, we_d;
   logic [31:0]      cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             gnt_q, gnt_d;
   logic             done_q, done_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             cpu_act_s;
   logic             beat_s;

   assign cpu_act_s  = cpu_memread | (cpu_memwrite != 2'd0);
   // A dropped request suppresses the beat in the very cycle it falls.
   assign beat_s     = (state_q == ST_XFER) && (remaining_q != LEN_ZERO) && dma_req && !cpu_act_s;
   assign cpu_rdata  = mem_rdata;
   assign dma_gnt    = gnt_q;
   assign dma_beat   = beat_s;
   assign dma_rdata  = rdata_q;
   assign dma_rvalid = rvalid_q;
   assign dma_done   = done_q;

   // Burst sequencing and the read-return pipeline.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (dma_req) begin
               we_d        = dma_we;
               cur_addr_d  = dma_addr;
               remaining_d = dma_len;
               state_d     = (dma_len == LEN_ZERO) ? ST_DONE : ST_XFER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (!dma_req) begin
               state_d = ST_IDLE;
            end else if (beat_s) begin
               cur_addr_d  = cur_addr_q + ADDR_INC;
               remaining_d = remaining_q - LEN_ONE;
               if (remaining_q == LEN_ONE) begin
                  state_d = we_q ? ST_DONE : ST_DRAIN;
               end else begin
                  state_d = ST_XFER;
               end
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      gnt_d     = (state_d == ST_XFER) || (state_d == ST_DRAIN);
      done_d    = (state_d == ST_DONE);
      rd_pend_d = beat_s && !we_q;
      rvalid_d  = rd_pend_q;
      rdata_d   = rd_pend_q ? mem_rdata : rdata_q;
   end

   // Memory command mux: CPU first, then the pending DMA beat, else idle.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 2'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (cpu_act_s) begin
         mem_read  = cpu_memread;
         mem_write = cpu_memwrite;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (beat_s) begin
         mem_addr  = cur_addr_q;
         mem_read  = !we_q;
         mem_write = we_q ? 2'd2 : 2'd0;
         mem_wdata = we_q ? dma_wdata : 32'd0;
      end else begin
         mem_read  = 1'b0;
         mem_write = 2'd0;
         mem_addr  = 32'd0;
         mem_wdata = 32'd0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         cur_addr_q  <= 32'd0;
         remaining_q <= LEN_ZERO;
         gnt_q       <= 1'b0;
         done_q      <= 1'b0;
         rd_pend_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rd_pend_q   <= rd_pend_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle output masks plus a beat/read-data scoreboard.
module tb_mem_bus_arbiter;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cpu_memread;
   logic [1:0]       cpu_memwrite;
   logic [31:0]      cpu_addr;
   logic [31:0]      cpu_wdata;
   logic [31:0]      cpu_rdata;
   logic             dma_req;
   logic             dma_we;
   logic [31:0]      dma_addr;
   logic [LEN_W-1:0] dma_len;
   logic [31:0]      dma_wdata;
   logic             dma_gnt;
   logic             dma_beat;
   logic [31:0]      dma_rdata;
   logic             dma_rvalid;
   logic             dma_done;
   logic             mem_read;
   logic [1:0]       mem_write;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata = 32'hDEAD_BEEF;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   beat_t       exp_beat_q[$];
   logic [31:0] exp_rd_q[$];

   mem_bus_arbiter #(.ADDR_STEP(2), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid), .dma_done(dma_done),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: returns address + 0x1000, garbage when not read.
   always @(posedge clk) mem_rdata <= mem_read ? (mem_addr + 32'h0000_1000) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every issued beat and every read return is popped and compared.
   always @(negedge clk) begin
      if (dma_beat === 1'b1) begin
         chk("beat_expected", 32'(exp_beat_q.size() != 0), 32'd1);
         if (exp_beat_q.size() != 0) begin
            beat_t b;
            b = exp_beat_q.pop_front();
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_read", {31'd0, mem_read}, {31'd0, !b.we});
            chk("beat_write", {30'd0, mem_write}, b.we ? 32'd2 : 32'd0);
            if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
         end
      end
      if (dma_rvalid === 1'b1) begin
         chk("rvalid_expected", 32'(exp_rd_q.size() != 0), 32'd1);
         if (exp_rd_q.size() != 0) chk("rdata", dma_rdata, exp_rd_q.pop_front());
      end
   end

   task automatic push_exp(input logic we, input logic [31:0] addr, input int nbeats,
                           input int nrd, input logic [31:0] wdata);
      for (int i = 0; i < nbeats; i++) begin
         beat_t b;
         b.addr  = addr + 32'(2 * i);
         b.we    = we;
         b.wdata = wdata;
         exp_beat_q.push_back(b);
         if (!we && i < nrd) exp_rd_q.push_back(addr + 32'(2 * i) + 32'h0000_1000);
      end
   endtask

   // Cycle 0 drives the request; cycle k is the k-th cycle after it is sampled.
   task automatic run_burst(input string name, input logic we, input logic [31:0] addr,
                            input logic [7:0] len, input logic [15:0] cpu_m, input int drop_k,
                            input logic [15:0] beat_m, input logic [15:0] rv_m,
                            input logic [15:0] done_m, input logic [15:0] gnt_m, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            dma_req  = 1'b1;
            dma_we   = we;
            dma_addr = addr;
            dma_len  = len;
         end
         if (k == drop_k) dma_req = 1'b0;
         cpu_memread = cpu_m[k];
         cpu_addr    = cpu_m[k] ? 32'h0000_9000 : 32'd0;
         @(negedge clk);
         chk($sformatf("%s beat c%0d", name, k), {31'd0, dma_beat}, {31'd0, beat_m[k]});
         chk($sformatf("%s rvalid c%0d", name, k), {31'd0, dma_rvalid}, {31'd0, rv_m[k]});
         chk($sformatf("%s done c%0d", name, k), {31'd0, dma_done}, {31'd0, done_m[k]});
         chk($sformatf("%s gnt c%0d", name, k), {31'd0, dma_gnt}, {31'd0, gnt_m[k]});
         if (cpu_m[k]) begin
            chk($sformatf("%s cpu_addr c%0d", name, k), mem_addr, 32'h0000_9000);
            chk($sformatf("%s cpu_read c%0d", name, k), {31'd0, mem_read}, 32'd1);
            chk($sformatf("%s cpu_rdata c%0d", name, k), cpu_rdata, mem_rdata);
         end
      end
      cpu_memread = 1'b0;
      cpu_addr    = 32'd0;
      chk({name, " beats_left"}, 32'(exp_beat_q.size()), 32'd0);
      chk({name, " reads_left"}, 32'(exp_rd_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_memread = 1'b0; cpu_memwrite = 2'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_len = 8'd0; dma_wdata = 32'd0;
      #2;
      chk("rst gnt", {31'd0, dma_gnt}, 32'd0);
      chk("rst rvalid", {31'd0, dma_rvalid}, 32'd0);
      chk("rst rdata", dma_rdata, 32'd0);
      chk("rst mem_addr idle", mem_addr, 32'd0);
      cpu_memwrite = 2'd1; cpu_addr = 32'h0000_0ABC; cpu_wdata = 32'h1234_5678;
      #1;
      chk("rst cpu mem_write", {30'd0, mem_write}, 32'd1);
      chk("rst cpu mem_addr", mem_addr, 32'h0000_0ABC);
      chk("rst cpu mem_wdata", mem_wdata, 32'h1234_5678);
      cpu_memwrite = 2'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      dma_wdata = 32'hCAFE_0001;
      push_exp(1'b1, 32'h0000_0100, 4, 0, 32'hCAFE_0001);
      run_burst("wr4", 1'b1, 32'h0000_0100, 8'd4, 16'h0000, 6,
                16'h001E, 16'h0000, 16'h0020, 16'h001E, 7);

      push_exp(1'b0, 32'h0000_0040, 3, 3, 32'd0);
      run_burst("rd3", 1'b0, 32'h0000_0040, 8'd3, 16'h0000, 6,
                16'h000E, 16'h0038, 16'h0020, 16'h001E, 7);

      push_exp(1'b0, 32'h0000_0200, 5, 5, 32'd0);
      run_burst("coll", 1'b0, 32'h0000_0200, 8'd5, 16'h001C, 11,
                16'h01E2, 16'h0788, 16'h0400, 16'h03FE, 12);

      dma_wdata = 32'h5A5A_0002;
      push_exp(1'b1, 32'hFFFF_FFFE, 2, 0, 32'h5A5A_0002);
      run_burst("wrap", 1'b1, 32'hFFFF_FFFE, 8'd2, 16'h0000, 4,
                16'h0006, 16'h0000, 16'h0008, 16'h0006, 5);

      run_burst("len0", 1'b1, 32'h0000_0300, 8'd0, 16'h0000, 2,
                16'h0000, 16'h0000, 16'h0002, 16'h0000, 4);

      push_exp(1'b0, 32'h0000_0500, 2, 2, 32'd0);
      run_burst("abort", 1'b0, 32'h0000_0500, 8'd5, 16'h0000, 3,
                16'h0006, 16'h0018, 16'h0000, 16'h000E, 8);

      // Reset in the middle of a read burst.
      push_exp(1'b0, 32'h0000_0600, 3, 1, 32'd0);
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0600; dma_len = 8'd6;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("mrst beat c%0d", k), {31'd0, dma_beat}, 32'd1);
         chk($sformatf("mrst rvalid c%0d", k), {31'd0, dma_rvalid}, (k == 3) ? 32'd1 : 32'd0);
      end
      #2;
      rst_n = 1'b0;
      dma_req = 1'b0;
      #1;
      chk("mrst gnt", {31'd0, dma_gnt}, 32'd0);
      chk("mrst beat", {31'd0, dma_beat}, 32'd0);
      chk("mrst rvalid", {31'd0, dma_rvalid}, 32'd0);
      chk("mrst done", {31'd0, dma_done}, 32'd0);
      chk("mrst rdata", dma_rdata, 32'd0);
      cpu_memwrite = 2'd3; cpu_addr = 32'h0000_1234; cpu_wdata = 32'h0000_0055;
      #1;
      chk("mrst cpu mem_write", {30'd0, mem_write}, 32'd3);
      chk("mrst cpu mem_addr", mem_addr, 32'h0000_1234);
      repeat (2) @(posedge clk);
      #1;
      cpu_memwrite = 2'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("post gnt c%0d", k), {31'd0, dma_gnt}, 32'd0);
         chk($sformatf("post beat c%0d", k), {31'd0, dma_beat}, 32'd0);
         chk($sformatf("post rvalid c%0d", k), {31'd0, dma_rvalid}, 32'd0);
         chk($sformatf("post done c%0d", k), {31'd0, dma_done}, 32'd0);
      end
      chk("post beats_left", 32'(exp_beat_q.size()), 32'd0);
      chk("post reads_left", 32'(exp_rd_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory port between the CPU and one DMA master. The CPU has absolute priority and is never stalled, since it has no wait input. DMA bursts are issued one beat at a time, only in cycles where the CPU drives neither read nor write. The block sits between the CPU/DMA masters and the memory, and owns the memory command lines (read, write code, address, write data).

## Interface
- ADDR_STEP, 2: address increment per DMA beat (memory is halfword-addressed).
- LEN_W, 8: width of the DMA burst length.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_memread  in  1  CPU read strobe.
- cpu_memwrite  in  2  CPU write code: 0 none, 1 word, 3 byte (2 never issued by the CPU).
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  equals mem_rdata (combinational pass-through).
- dma_req  in  1  burst request; held high for the whole burst.
- dma_we  in  1  1 = burst writes, 0 = burst reads; sampled with dma_req.
- dma_addr  in  32  burst start address; sampled with dma_req.
- dma_len  in  LEN_W  beat count; sampled with dma_req.
- dma_wdata  in  32  write data for the current beat.
- dma_gnt  out  1  high while the burst is active.
- dma_beat  out  1  1-cycle pulse when a beat is issued to memory.
- dma_rdata  out  32  registered read data.
- dma_rvalid  out  1  1-cycle pulse when dma_rdata is valid.
- dma_done  out  1  1-cycle pulse at burst completion.
- mem_read  out  1  memory read strobe.
- mem_write  out  2  memory write code: 0 none, 1 word, 2 DMA word, 3 byte.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the cycle after the read is issued (synchronous read).

## Operation
- cpu_act = cpu_memread | (cpu_memwrite != 0).
- **Mux priority (combinational):**
  - If cpu_act, the mem_* outputs carry the CPU signals unchanged.
  - Else, if the state is XFER and beats remain, the mem_* outputs carry the DMA beat:
    - mem_addr = cur_addr.
    - Read burst: mem_read = 1.
    - Write burst: mem_write = 2, mem_wdata = dma_wdata.
  - Otherwise all mem_* outputs are 0.
- **FSM states:** IDLE, XFER, DRAIN, DONE.
- **IDLE:**
  - On dma_req = 1, latch dma_we, cur_addr = dma_addr, and remaining = dma_len.
  - Go to XFER, or to DONE if dma_len = 0.
- **XFER:**
  - dma_gnt = 1.
  - A beat issues in every cycle where cpu_act = 0.
  - On each beat: dma_beat = 1, cur_addr += ADDR_STEP (wraps mod 2^32), remaining -= 1.
  - On the last beat: a read burst goes to DRAIN, a write burst goes to DONE.
- **DRAIN:** dma_gnt = 1; after one cycle, go to DONE.
- **DONE:** dma_done = 1 for one cycle; return to IDLE. A new request is accepted no earlier than the cycle after DONE.
- **Read return:** for a DMA read beat issued in cycle t:
  - mem_rdata is captured at the end of cycle t+1.
  - dma_rvalid is high in cycle t+2.
  - This holds regardless of CPU traffic in t+1.
- **CPU collision:** if cpu_act rises in the cycle a beat would issue, the CPU wins. The beat is deferred and remaining/cur_addr are unchanged. There is no starvation limit.
- **Abort:** dma_req = 0 while in XFER:
  - No further beats issue from that cycle.
  - Go to IDLE with no dma_done.
  - A read already issued still produces its dma_rvalid.

## Timing
- Reset (asserted asynchronously):
  - State IDLE; cur_addr, remaining and dma_rdata = 0.
  - dma_gnt, dma_beat, dma_rvalid and dma_done = 0.
  - mem_* outputs follow the CPU inputs (all 0 if the CPU is idle).
- Reset mid-burst: the burst is discarded, and no dma_rvalid or dma_done is produced after release.
- Request-to-first-beat latency: 1 cycle (request sampled at edge e; first possible beat in the cycle after e).
- Peak throughput: 1 beat per cycle.
- Completion time for an N-beat write burst with no CPU traffic: beats in cycles 1..N, dma_done in cycle N+1.
- Completion time for a read burst with no CPU traffic: dma_done in cycle N+2, concurrent with the last dma_rvalid.
- The CPU path adds no register stage. The CPU observes identical timing with or without the arbiter.

## Test plan
- **4-beat write burst, CPU idle:** dma_req with addr 0x100, len 4, we = 1 → mem_write = 2 at addresses 0x100, 0x102, 0x104, 0x106 in consecutive cycles; dma_done one cycle after the last beat.
- **3-beat read burst:** read from 0x40, with memory returning addr+0x1000 → dma_rvalid pulses carry 0x1040, 0x1042, 0x1044, each 2 cycles after its beat; dma_done coincides with the last pulse.
- **CPU collision:** CPU holds cpu_memread for 3 cycles starting mid-burst → no dma_beat in those cycles; mem_addr = cpu_addr; the burst resumes at the deferred address with no skip or duplicate.
- **Wrap and zero length:**
  - Start at 0xFFFFFFFE, len 2 → second beat at 0x00000000.
  - len 0 → no beats; dma_done one cycle after the request is sampled.
- **Abort:** drop dma_req after 2 beats of a 5-beat read → exactly 2 dma_rvalid pulses, no dma_done, FSM back in IDLE.
- **Reset:** assert rst_n = 0 mid-burst → all dma_* outputs are 0 immediately, and nothing further after release.
